// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register fields are stored at REG_AW_MAX bits; narrower register addresses are zero-extended.
package pipe_pkg;

  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned FWD_NONE   = 0;

  localparam logic [REG_AW_MAX-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
    logic [REG_AW_MAX-1:0] rs1;
    logic [REG_AW_MAX-1:0] rs2;
    logic                  rs1_use;
    logic                  rs2_use;
  } sb_entry_t;

  // x0 is never a writer, so it can never create a dependency.
  function automatic logic is_writer(input sb_entry_t e, input logic [REG_AW_MAX-1:0] r);
    return e.valid && e.regwrite && (e.rd != REG_X0) && (e.rd == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight instruction scoreboard: entry 0 is EX, the highest entry is WB.
// Shifts one stage per enabled cycle and takes a bubble instead of ID when asked.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      bubble,
  input  sb_entry_t id_entry,
  output sb_entry_t entries [STAGES]
);

  sb_entry_t sb_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sb_q[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = STAGES - 1; k > 0; k--) begin
        sb_q[k] <= sb_q[k-1];
      end
      sb_q[0] <= bubble ? '0 : id_entry;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      entries[k] = sb_q[k];
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: load-use stall/bubble, taken-branch flush and EX forwarding selects.
// Stall/flush performance counters are built only when HAZ_STATS_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FW       = $clog2(STAGES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [FW-1:0]     fwd_rs1_sel_o,
  output logic [FW-1:0]     fwd_rs2_sel_o
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  sb_entry_t sb [STAGES];
  sb_entry_t id_entry;
  logic      active;
  logic      hazard;
  logic      stall;
  logic      flush;
  logic [FW-1:0] sel1;
  logic [FW-1:0] sel2;

  // Outputs are forced low during reset so nothing leaks from the pre-reset scoreboard.
  assign active = start_i & ~rst_i;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid_i;
    id_entry.rd       = REG_AW_MAX'(id_rd_i);
    id_entry.regwrite = id_regwrite_i;
    id_entry.is_load  = id_memread_i;
    id_entry.rs1      = REG_AW_MAX'(id_rs1_i);
    id_entry.rs2      = REG_AW_MAX'(id_rs2_i);
    id_entry.rs1_use  = id_rs1_use_i;
    id_entry.rs2_use  = id_rs2_use_i;
  end

  hazard_scoreboard #(
    .STAGES (STAGES)
  ) u_scoreboard (
    .clk      (clk_i),
    .rst      (rst_i),
    .advance  (start_i),
    .bubble   (stall),
    .id_entry (id_entry),
    .entries  (sb)
  );

  always_comb begin
    hazard = 1'b0;
    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
      if (sb[j].is_load &&
          ((id_rs1_use_i && is_writer(sb[j], id_entry.rs1)) ||
           (id_rs2_use_i && is_writer(sb[j], id_entry.rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall = active & id_valid_i & hazard;
  assign flush = active & id_valid_i & branch_taken_i & ~stall;

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    sel1 = FW'(FWD_NONE);
    sel2 = FW'(FWD_NONE);
    if (active && sb[0].valid) begin
      for (int unsigned k = STAGES - 1; k >= 1; k--) begin
        if (sb[0].rs1_use && is_writer(sb[k], sb[0].rs1)) begin
          sel1 = FW'(k);
        end
        if (sb[0].rs2_use && is_writer(sb[k], sb[0].rs2)) begin
          sel2 = FW'(k);
        end
      end
    end
  end

  assign stall_o       = stall;
  assign bubble_o      = stall;
  assign flush_o       = flush;
  assign fwd_rs1_sel_o = sel1;
  assign fwd_rs2_sel_o = sel2;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations (3 stages/LOAD_LAT 1 and 4 stages/LOAD_LAT 2)
// share the ID stimulus and are each checked against an in-flight history model; counters with HAZ_STATS_EN.
module tb_pipe_hazard_ctrl;

  localparam int unsigned SA = 3, LA = 1, SB = 4, LB = 2, AW = 5;

  logic clk;
  logic rst, start, id_valid, u1, u2, rw, ld, br;
  logic [AW-1:0] rs1, rs2, rd;
  logic a_stall, a_bubble, a_flush, b_stall, b_bubble, b_flush;
  logic [$clog2(SA)-1:0] a_f1, a_f2;
  logic [$clog2(SB)-1:0] b_f1, b_f2;
`ifdef HAZ_STATS_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  pipe_hazard_ctrl #(.STAGES(SA), .REG_AW(AW), .LOAD_LAT(LA)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_use_i(u1), .id_rs2_use_i(u2),
    .id_rd_i(rd), .id_regwrite_i(rw), .id_memread_i(ld), .branch_taken_i(br),
    .stall_o(a_stall), .bubble_o(a_bubble), .flush_o(a_flush),
    .fwd_rs1_sel_o(a_f1), .fwd_rs2_sel_o(a_f2)
`ifdef HAZ_STATS_EN
    , .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
`endif
  );

  pipe_hazard_ctrl #(.STAGES(SB), .REG_AW(AW), .LOAD_LAT(LB)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_use_i(u1), .id_rs2_use_i(u2),
    .id_rd_i(rd), .id_regwrite_i(rw), .id_memread_i(ld), .branch_taken_i(br),
    .stall_o(b_stall), .bubble_o(b_bubble), .flush_o(b_flush),
    .fwd_rs1_sel_o(b_f1), .fwd_rs2_sel_o(b_f2)
`ifdef HAZ_STATS_EN
    , .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit valid; int rd; bit rw; bit ld; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  // History of what entered EX: index k = instruction that is k stages past EX.
  ins_t pa[$];
  ins_t pb[$];
  int tests = 0;
  int fails = 0;
  bit exp_stall[2];
  int exp_sc[2];
  int exp_fc[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit wr(input ins_t e, input int r);
    return e.valid && e.rw && e.rd != 0 && e.rd == r;
  endfunction

  function automatic ins_t cur_id();
    ins_t e;
    e.valid = id_valid; e.rd = int'(rd); e.rw = rw; e.ld = ld;
    e.rs1 = int'(rs1); e.rs2 = int'(rs2); e.u1 = u1; e.u2 = u2;
    return e;
  endfunction

  function automatic bit m_stall(input ins_t p[$], input int ll, input ins_t id);
    if (rst || !start || !id.valid) return 1'b0;
    for (int j = 0; j < ll; j++)
      if (p[j].ld && ((id.u1 && wr(p[j], id.rs1)) || (id.u2 && wr(p[j], id.rs2)))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(input ins_t p[$], input bit second);
    ins_t e;
    int r;
    e = p[0];
    if (rst || !start || !e.valid) return 0;
    if (second ? !e.u2 : !e.u1) return 0;
    r = second ? e.rs2 : e.rs1;
    for (int k = 1; k < p.size(); k++)
      if (wr(p[k], r)) return k;
    return 0;
  endfunction

  task automatic reset_model();
    ins_t blank;
    blank = '{default: 0};
    pa.delete();
    pb.delete();
    for (int k = 0; k < int'(SA); k++) pa.push_back(blank);
    for (int k = 0; k < int'(SB); k++) pb.push_back(blank);
    exp_sc = '{0, 0};
    exp_fc = '{0, 0};
  endtask

  // Check one cycle at the falling edge, then advance the model past the rising edge.
  task automatic step();
    ins_t id, e;
    bit sa, sb, fa, fb;
    @(negedge clk);
    id = cur_id();
    sa = m_stall(pa, LA, id);
    sb = m_stall(pb, LB, id);
    fa = !rst && start && id.valid && br && !sa;
    fb = !rst && start && id.valid && br && !sb;
    chk("a_stall", 32'(a_stall), 32'(sa));
    chk("a_bubble", 32'(a_bubble), 32'(sa));
    chk("a_flush", 32'(a_flush), 32'(fa));
    chk("a_fwd1", 32'(a_f1), 32'(m_fwd(pa, 1'b0)));
    chk("a_fwd2", 32'(a_f2), 32'(m_fwd(pa, 1'b1)));
    chk("b_stall", 32'(b_stall), 32'(sb));
    chk("b_bubble", 32'(b_bubble), 32'(sb));
    chk("b_flush", 32'(b_flush), 32'(fb));
    chk("b_fwd1", 32'(b_f1), 32'(m_fwd(pb, 1'b0)));
    chk("b_fwd2", 32'(b_f2), 32'(m_fwd(pb, 1'b1)));
    exp_stall[0] = sa;
    exp_stall[1] = sb;
    @(posedge clk);
    #1;
    if (rst) begin
      reset_model();
    end else begin
      if (sa) exp_sc[0]++;
      if (sb) exp_sc[1]++;
      if (fa) exp_fc[0]++;
      if (fb) exp_fc[1]++;
      if (start) begin
        e = id; e.valid = id.valid && !sa;
        pa.push_front(e); void'(pa.pop_back());
        e = id; e.valid = id.valid && !sb;
        pb.push_front(e); void'(pb.pop_back());
      end
    end
  endtask

  task automatic set_id(input bit v, input int r1, input bit uu1, input int r2, input bit uu2,
                        input int d, input bit w, input bit l, input bit b);
    id_valid = v; rs1 = AW'(r1); u1 = uu1; rs2 = AW'(r2); u2 = uu2;
    rd = AW'(d); rw = w; ld = l; br = b;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (5) step();
  endtask

  // Hold the current ID instruction until the target configuration lets it issue.
  task automatic issue(input int tgt, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (exp_stall[tgt]) n++;
      else done = 1'b1;
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL issue_bound: observed %0d stall cycles expected release within 10", n);
    end
  endtask

  initial begin
    int n;
    reset_model();
    rst = 1'b1;
    start = 1'b1;
    set_id(1'b1, 5, 1'b1, 6, 1'b1, 7, 1'b1, 1'b1, 1'b1);
    step();
    step();
    rst = 1'b0;
    set_id(1'b1, 5, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0, 1'b0);
    #2;
    chk("reset_no_stall", 32'(a_stall), 32'd0);
    issue(0, n);
    nop();
    #2;
    chk("reset_no_fwd", 32'(a_f1), 32'd0);
    drain();

    // ALU RAW, back to back and with one independent instruction between
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 5, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0); issue(0, n);
    chk("raw_no_stall", 32'(n), 32'd0);
    nop(); #2;
    chk("raw_fwd_sel1", 32'(a_f1), 32'd1);
    drain();
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 5, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0); issue(0, n);
    nop(); #2;
    chk("raw_gap_fwd_a", 32'(a_f1), 32'd2);
    chk("raw_gap_fwd_b", 32'(b_f1), 32'd2);
    drain();

    // load-use on rs2, LOAD_LAT=1
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1, 1'b0); issue(0, n);
    set_id(1'b1, 3, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0, 1'b0); issue(0, n);
    chk("lu_a_stall_cycles", 32'(n), 32'd1);
    nop(); #2;
    chk("lu_a_fwd2", 32'(a_f2), 32'd2);
    drain();

    // x0 never matches; youngest of two writers wins
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0); issue(0, n);
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0); issue(0, n);
    chk("x0_no_stall", 32'(n), 32'd0);
    nop(); #2;
    chk("x0_no_fwd", 32'(a_f1), 32'd0);
    drain();
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0); issue(0, n);
    nop(); #2;
    chk("prio_youngest", 32'(a_f1), 32'd1);
    drain();

    // taken branch, then taken branch behind a load-use hazard
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1); #2;
    chk("br_flush", 32'(a_flush), 32'd1);
    step();
    nop(); #2;
    chk("br_flush_drop", 32'(a_flush), 32'd0);
    step();
    drain();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0); issue(0, n);
    set_id(1'b1, 8, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); #2;
    chk("brlu_stall", 32'(a_stall), 32'd1);
    chk("brlu_no_flush", 32'(a_flush), 32'd0);
    step(); #2;
    chk("brlu_stall_clear", 32'(a_stall), 32'd0);
    chk("brlu_flush", 32'(a_flush), 32'd1);
    step();
    drain();

    // LOAD_LAT=2, STAGES=4
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 10, 1'b1, 1'b1, 1'b0); issue(1, n);
    set_id(1'b1, 10, 1'b1, 0, 1'b0, 12, 1'b1, 1'b0, 1'b0); issue(1, n);
    chk("lu_b_direct_cycles", 32'(n), 32'd2);
    drain();
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 11, 1'b1, 1'b1, 1'b0); issue(1, n);
    set_id(1'b1, 2, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0); issue(1, n);
    set_id(1'b1, 11, 1'b1, 0, 1'b0, 14, 1'b1, 1'b0, 1'b0); issue(1, n);
    chk("lu_b_gap_cycles", 32'(n), 32'd1);
    nop(); #2;
    chk("lu_b_gap_fwd", 32'(b_f1), 32'd3);
    drain();

    // reset in the middle of a stall
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 6, 1'b1, 1'b1, 1'b0); issue(0, n);
    set_id(1'b1, 6, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0, 1'b0); #2;
    chk("rst_mid_stall_pre", 32'(a_stall), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; #2;
    chk("rst_mid_stall_post", 32'(a_stall), 32'd0);
    step();
    drain();

    // start_i low freezes the scoreboard and silences outputs
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 12, 1'b1, 1'b0, 1'b0); issue(0, n);
    set_id(1'b1, 12, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0); issue(0, n);
    start = 1'b0;
    nop(); #2;
    chk("freeze_fwd_off", 32'(a_f1), 32'd0);
    step();
    step();
    start = 1'b1; #2;
    chk("freeze_fwd_resume", 32'(a_f1), 32'd1);
    step();
    drain();

    // randomized traffic over a small register window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 9) != 0);
      set_id(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      step();
    end
    rst = 1'b0;
    start = 1'b1;
    drain();

`ifdef HAZ_STATS_EN
    chk("a_stall_cnt", a_sc, 32'(exp_sc[0]));
    chk("a_flush_cnt", a_fc, 32'(exp_fc[0]));
    chk("b_stall_cnt", b_sc, 32'(exp_sc[1]));
    chk("b_flush_cnt", b_fc, 32'(exp_fc[1]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It tracks in-flight register writers in an internal scoreboard that shifts with the pipeline. It produces the load-use stall, the ID/EX bubble, the IF/ID flush for taken branches, and the per-operand forwarding selects for the instruction currently in EX. It sits beside the decode stage and drives PCWrite, the IF/ID hold/flush, the ID/EX control-zeroing and the EX operand muxes.

## Interface
- `STAGES`, default 3: scoreboard depth, counted from EX. Entry 0 is EX, entry 1 is MEM, entry STAGES-1 is WB. Minimum 2.
- `REG_AW`, default 5: register address width.
- `LOAD_LAT`, default 1: stages after EX before load data is forwardable. Range 1 to STAGES-1.
- `FW`, default $clog2(STAGES): forwarding select width. Derived; do not override.

- `clk_i` input, 1: clock.
- `rst_i` input, 1: synchronous, active-high reset.
- `start_i` input, 1: core run enable. While 0, the scoreboard is held and all hazard outputs are 0.
- `id_valid_i` input, 1: ID holds a real instruction.
- `id_rs1_i`, `id_rs2_i` input, REG_AW: ID source registers.
- `id_rs1_use_i`, `id_rs2_use_i` input, 1: the instruction reads that source.
- `id_rd_i` input, REG_AW: ID destination register.
- `id_regwrite_i` input, 1: the ID instruction writes rd.
- `id_memread_i` input, 1: the ID instruction is a load.
- `branch_taken_i` input, 1: the branch resolved in ID is taken.
- `stall_o` output, 1: hold PC and IF/ID.
- `bubble_o` output, 1: zero the ID/EX control signals this cycle.
- `flush_o` output, 1: clear IF/ID at the next edge.
- `fwd_rs1_sel_o`, `fwd_rs2_sel_o` output, FW: EX operand source. 0 selects the ID/EX register value; k≥1 selects the result held by scoreboard entry k.
- `stall_cnt_o`, `flush_cnt_o` output, 32: performance counters. Present only with HAZ_STATS_EN.

## Operation
- Scoreboard entry fields: valid, rd, regwrite, is_load, rs1, rs2, rs1_use, rs2_use.
- An entry is a writer only when valid=1, regwrite=1 and rd≠0. x0 never matches.
- **Load-use hazard.** Raised when an ID source that is in use matches a writer at entry j with is_load=1 and j < LOAD_LAT.
- Stall condition: stall = start_i & id_valid_i & load-use hazard.
- When stalled: `stall_o` = `bubble_o` = 1.
- **Flush.** flush_o = start_i & id_valid_i & branch_taken_i & !stall.
  - Stall has priority; the branch is re-evaluated once the stall clears.
  - The branch itself issues normally; only the wrong-path fetch is flushed.
- **Forwarding.** Computed for entry 0 (the EX instruction) when entry 0 is valid and its source is in use.
  - Search entries 1..STAGES-1 for a writer with a matching rd.
  - The youngest match (lowest index) wins, and the select equals that index.
  - No match, an invalid entry 0, or an unused source gives select 0.
- **Scoreboard update** at the clock edge when start_i=1:
  - Entries shift: entry k+1 takes entry k; the oldest entry is discarded.
  - Entry 0 loads the ID instruction fields with valid=id_valid_i & !stall.
  - On a stall, entry 0 loads an invalid bubble while the older entries still advance.
- Reset: all entries cleared to valid=0; counters cleared.

## Timing
- `stall_o`, `bubble_o`, `flush_o` and the fwd selects are combinational from the registered scoreboard and the current ID inputs. There is no added latency.
- A load followed directly by a dependent instruction stalls exactly LOAD_LAT cycles.
- Output values during and after reset: `stall_o`, `bubble_o` and `flush_o` are 0 and both fwd selects are 0. They stay there until an instruction issues.
- Reset mid-stall drops all in-flight entries. The stall deasserts in the first cycle after reset.
- start_i=0 freezes the scoreboard. Forwarding selects reflect the frozen state once start_i returns.

## Configuration
- `HAZ_STATS_EN` defined:
  - `stall_cnt_o` increments each cycle `stall_o`=1.
  - `flush_cnt_o` increments each cycle `flush_o`=1.
  - Both counters wrap at 2^32 and clear on reset.
- `HAZ_STATS_EN` undefined: the counter ports and their logic are absent.

## Structure
- Shared package `pipe_pkg` holds:
  - the `sb_entry_t` struct (the scoreboard entry fields);
  - `FWD_NONE`=0;
  - the `REG_X0` constant.
- Sub-module `hazard_scoreboard` holds the shift register, the bubble insertion and the reset. The top level holds the match, stall, flush and forward logic.

## Test plan
- Reset: assert rst_i for 2 cycles with id_valid_i=1. Required: all outputs 0 and the scoreboard empty; no forwarding for the next instruction.
- ALU RAW: `add x5` then `sub` with rs1=x5. Required: no stall; `fwd_rs1_sel_o`=1 in the sub's EX cycle. Insert one independent instruction between them: select=2.
- Load-use, LOAD_LAT=1: `lw x6` then a consumer with rs2=x6. Required: `stall_o`=`bubble_o`=1 for exactly 1 cycle, then `fwd_rs2_sel_o`=2 in the consumer's EX cycle.
- x0 and priority: `lw x0` then a consumer of x0. Required: no stall, select 0. Two writers of x7 in entries 1 and 2: select=1.
- Branch: branch_taken_i=1 with no hazard. Required: `flush_o`=1 for one cycle. Branch taken together with a load-use hazard: `stall_o`=1 and `flush_o`=0, then `flush_o`=1 on the following cycle.
- LOAD_LAT=2, STAGES=4: a load directly followed by its consumer stalls 2 cycles. With one independent instruction between them, 1 cycle. With `HAZ_STATS_EN` defined, `stall_cnt_o` equals the total number of stall cycles.
